// File: rtl/approx_mul_8x8_pair_seq.sv
// Sequential 8x8 unsigned multiplier built around one row-pair reduction unit.
// The x operand is walked two bits at a time; each step adds the reduced pair
// of partial-product rows, shifted into place, to a 16-bit accumulator.

// One row-pair reduction: rows y&x[0] (cols 0..7) and y&x[1] (cols 1..8)
// compressed by one half adder per column, then a single carry-propagate add.
// With approx_en the low columns trade accuracy for shorter carry paths:
// column 1 is dropped and columns 2..4 keep only the OR of their two bits.
module approx_mul_pair_unit (
    input  logic       approx_en,
    input  logic [7:0] y,
    input  logic [1:0] xp,
    output logic [9:0] pk
);
    logic [8:0] a, b, s, cy;

    assign a = {1'b0, y & {8{xp[0]}}};
    assign b = {y & {8{xp[1]}}, 1'b0};

    // Per-column half adders, with the approximate columns overridden
    always_comb begin
        s  = a ^ b;
        cy = a & b;
        if (approx_en) begin
            s[1]    = 1'b0;
            cy[1]   = 1'b0;
            s[4:2]  = a[4:2] | b[4:2];
            cy[4:2] = 3'b000;
        end
    end

    assign pk = {1'b0, s} + {cy, 1'b0};
endmodule

module approx_mul_8x8_pair_seq #(
    parameter int APPROX_PAIR0 = 1,
    parameter int SKIP_ZERO    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } ops_t;

    state_t      state, state_nxt;
    ops_t        ops;
    logic [15:0] acc, acc_sum, p_r;
    logic [1:0]  cnt, first_cnt, nxt_cnt;
    logic        nxt_found, accept, in_zero;
    logic [3:0]  in_nz, run_nz;
    logic [9:0]  pk;

    assign in_nz   = {|x[7:6], |x[5:4], |x[3:2], |x[1:0]};
    assign run_nz  = {|ops.x[7:6], |ops.x[5:4], |ops.x[3:2], |ops.x[1:0]};
    assign in_zero = (x == 8'd0);

    // First pair to process for freshly accepted operands
    always_comb begin
        first_cnt = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (SKIP_ZERO == 0 || in_nz[k]) first_cnt = 2'(k);
        end
    end

    // Next pair after the current one; none left means this is the last step
    always_comb begin
        nxt_found = 1'b0;
        nxt_cnt   = cnt;
        for (int k = 3; k >= 0; k--) begin
            if (k > int'(cnt) && (SKIP_ZERO == 0 || run_nz[k])) begin
                nxt_found = 1'b1;
                nxt_cnt   = 2'(k);
            end
        end
    end

    approx_mul_pair_unit u_pair (
        .approx_en (APPROX_PAIR0 != 0 && cnt == 2'd0),
        .y         (ops.y),
        .xp        (ops.x[{cnt, 1'b0} +: 2]),
        .pk        (pk)
    );

    assign acc_sum = acc + (16'(pk) << {cnt, 1'b0});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = (SKIP_ZERO != 0 && in_zero) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!nxt_found) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        accept    = 1'b1;
                        state_nxt = (SKIP_ZERO != 0 && in_zero) ? DONE : RUN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, accumulation, and result latch on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops <= '0;
            acc <= '0;
            cnt <= '0;
            p_r <= '0;
        end else if (accept) begin
            ops <= '{x: x, y: y};
            acc <= '0;
            cnt <= first_cnt;
            if (SKIP_ZERO != 0 && in_zero) p_r <= '0;
        end else if (state == RUN) begin
            acc <= acc_sum;
            if (nxt_found) cnt <= nxt_cnt;
            else           p_r <= acc_sum;
        end
    end

    assign p    = p_r;
    assign busy = (state != IDLE);
endmodule
